// File: rtl/sys_arr_pkg.sv
// Shared systolic-array definitions: geometry defaults, MAC beat length,
// input-feeder FSM states and the skew-chain stage record.
package sys_arr_pkg;

    localparam int ARR_DIM = 4;
    localparam int DW      = 16;
    localparam int MUL_LEN = 2;
    localparam int ADD_LEN = 2;
    localparam int MAC_LEN = ADD_LEN + MUL_LEN;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2
    } feeder_state_t;

    // One skew-chain stage: a full input vector plus its occupancy flag.
    typedef struct packed {
        logic [ARR_DIM*DW-1:0] data;
        logic                  valid;
    } skew_stage_t;

    // Even parity over one stage, used for cheap integrity tagging of the chain.
    function automatic logic stage_parity(input skew_stage_t stage);
        return ^{stage.data, stage.valid};
    endfunction

endpackage

// File: rtl/sysarr_beat_counter.sv
// MAC beat phase counter: runs while the feeder is active, freezes on
// stall, and flags the last unstalled cycle of each beat.
module sysarr_beat_counter #(
    parameter int L = sys_arr_pkg::MAC_LEN
) (
    input  logic                 clk,
    input  logic                 nRST,
    input  logic                 active,
    input  logic                 stall_sa,
    output logic [$clog2(L)-1:0] count,
    output logic                 boundary
);

    localparam int CW = $clog2(L);
    localparam logic [CW-1:0] LAST_PHASE = CW'(L - 1);

    logic [CW-1:0] count_r;
    logic          at_last_s;

    // Phase register: parked at zero while idle, wraps L-1 -> 0, holds on stall
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            count_r <= {CW{1'b0}};
        end else if (!active) begin
            count_r <= {CW{1'b0}};
        end else if (!stall_sa) begin
            if (count_r == LAST_PHASE) begin
                count_r <= {CW{1'b0}};
            end else begin
                count_r <= count_r + CW'(1);
            end
        end else begin
            count_r <= count_r;
        end
    end

    // Beat-boundary decode
    always_comb begin
        at_last_s = (count_r == LAST_PHASE);
        boundary  = active & at_last_s & ~stall_sa;
        count     = count_r;
    end

endmodule

// File: rtl/sysarr_input_feeder.sv
// Systolic-array input feeder: accepts one vector per MAC beat and skews it
// across the rows so row i sees its lane i beats after row 0.
module sysarr_input_feeder
    import sys_arr_pkg::*;
#(
    parameter int N  = ARR_DIM,
    parameter int DW = sys_arr_pkg::DW,
    parameter int L  = MAC_LEN
) (
    input  logic                 clk,
    input  logic                 nRST,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*DW-1:0]      in_data,
    input  logic                 in_last,
    input  logic                 stall_sa,
    output logic [N*DW-1:0]      mac_in_value,
    output logic [N-1:0]         mac_shift,
    output logic [$clog2(L)-1:0] mac_count,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = $clog2(L);

    feeder_state_t state_r;
    feeder_state_t state_nxt_s;
    skew_stage_t   sk_r     [N];
    skew_stage_t   sk_nxt_s [N];
    logic          done_pend_r;
    logic          done_r;
    logic [CW-1:0] count_s;
    logic          boundary_s;
    logic          busy_s;
    logic          in_ready_s;
    logic          accept_s;
    logic          shift_s;
    logic          post_empty_s;
    logic          finish_s;

    assign busy_s = (state_r != IDLE);

    sysarr_beat_counter #(.L(L)) u_beat (
        .clk      (clk),
        .nRST     (nRST),
        .active   (busy_s),
        .stall_sa (stall_sa),
        .count    (count_s),
        .boundary (boundary_s)
    );

    // Handshake: idle accepts freely, FEED only on a beat boundary, DRAIN never
    always_comb begin
        if (stall_sa) begin
            in_ready_s = 1'b0;
        end else if (state_r == IDLE) begin
            in_ready_s = 1'b1;
        end else if (state_r == FEED) begin
            in_ready_s = boundary_s;
        end else begin
            in_ready_s = 1'b0;
        end
        accept_s = in_valid & in_ready_s;
        shift_s  = ((state_r == IDLE) & accept_s) | boundary_s;
    end

    // Skew-chain next value; a non-accepting shift injects a bubble at stage 0
    always_comb begin
        for (int k = 0; k < N; k++) begin
            sk_nxt_s[k] = sk_r[k];
        end
        if (shift_s) begin
            if (accept_s) begin
                sk_nxt_s[0].data  = in_data;
                sk_nxt_s[0].valid = 1'b1;
            end else begin
                sk_nxt_s[0] = '0;
            end
            for (int k = 1; k < N; k++) begin
                sk_nxt_s[k] = sk_r[k-1];
            end
        end else begin
            sk_nxt_s[0] = sk_r[0];
        end
        post_empty_s = 1'b1;
        for (int k = 0; k < N; k++) begin
            post_empty_s = post_empty_s & ~sk_nxt_s[k].valid;
        end
    end

    // FSM next state
    always_comb begin
        state_nxt_s = state_r;
        finish_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = in_last ? DRAIN : FEED;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            FEED: begin
                if (accept_s && in_last) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = FEED;
                end
            end
            DRAIN: begin
                if (boundary_s && post_empty_s) begin
                    state_nxt_s = IDLE;
                    finish_s    = 1'b1;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state and skew chain; both are already stall-qualified upstream
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_r <= IDLE;
            for (int k = 0; k < N; k++) begin
                sk_r[k] <= '0;
            end
        end else begin
            state_r <= state_nxt_s;
            for (int k = 0; k < N; k++) begin
                sk_r[k] <= sk_nxt_s[k];
            end
        end
    end

    // Completion pulse lands one cycle after IDLE is re-entered and waits out stalls
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            done_pend_r <= 1'b0;
            done_r      <= 1'b0;
        end else if (stall_sa) begin
            done_pend_r <= done_pend_r;
            done_r      <= 1'b0;
        end else begin
            done_pend_r <= finish_s;
            done_r      <= done_pend_r;
        end
    end

    // Row drive: stage i supplies lane i, shifted only at the start of a beat
    always_comb begin
        mac_in_value = {(N*DW){1'b0}};
        mac_shift    = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            mac_in_value[i*DW +: DW] = sk_r[i].data[i*DW +: DW];
            mac_shift[i] = busy_s & (count_s == {CW{1'b0}}) & sk_r[i].valid & ~stall_sa;
        end
    end

    assign in_ready  = in_ready_s;
    assign mac_count = count_s;
    assign busy      = busy_s;
    assign done      = done_r;

endmodule

// File: tb/tb_sysarr_input_feeder.sv
// Directed bench for sysarr_input_feeder (N=4, DW=16, L=4): a cycle table for a
// single-vector tile plus sequences for streaming, gaps, stall and reset.
module tb_sysarr_input_feeder;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int L  = 4;

    logic            clk;
    logic            nRST;
    logic            in_valid;
    logic            in_ready;
    logic [N*DW-1:0] in_data;
    logic            in_last;
    logic            stall_sa;
    logic [N*DW-1:0] mac_in_value;
    logic [N-1:0]    mac_shift;
    logic [1:0]      mac_count;
    logic            busy;
    logic            done;

    int errors;
    int checks;

    typedef struct {
        logic            vld;
        logic [N*DW-1:0] data;
        logic            last;
        logic            stall;
        logic            exp_rdy;
        logic [N-1:0]    exp_shift;
        logic [1:0]      exp_cnt;
        logic            exp_busy;
        logic            exp_done;
        logic [N*DW-1:0] exp_val;
    } vec_t;

    vec_t tv [20];

    sysarr_input_feeder #(.N(N), .DW(DW), .L(L)) dut (
        .clk          (clk),
        .nRST         (nRST),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .stall_sa     (stall_sa),
        .mac_in_value (mac_in_value),
        .mac_shift    (mac_shift),
        .mac_count    (mac_count),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [N*DW-1:0] d, input logic l, input logic s);
        in_valid = v;
        in_data  = d;
        in_last  = l;
        stall_sa = s;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [N*DW-1:0] v1, va, vb, vc, vr;
        logic [N*DW-1:0] d;
        logic [N-1:0]    es;
        logic [15:0]     lane;
        int              e;
        int              ndone;

        errors = 0;
        checks = 0;
        v1 = {16'd4, 16'd3, 16'd2, 16'd1};
        va = {16'hA3, 16'hA2, 16'hA1, 16'hA0};
        vb = {16'hB3, 16'hB2, 16'hB1, 16'hB0};
        vc = {16'hC3, 16'hC2, 16'hC1, 16'hC0};
        vr = {16'd8, 16'd7, 16'd6, 16'd5};

        // Single-vector tile: row i shifts lane value i+1 at c=1+4i, done at c=18
        for (int c = 0; c < 20; c++) begin
            tv[c].vld      = (c == 0);
            tv[c].data     = (c == 0) ? v1 : '0;
            tv[c].last     = (c == 0);
            tv[c].stall    = 1'b0;
            tv[c].exp_busy = (c >= 1) && (c <= 16);
            tv[c].exp_rdy  = !tv[c].exp_busy;
            tv[c].exp_cnt  = tv[c].exp_busy ? 2'((c - 1) % 4) : 2'd0;
            tv[c].exp_done = (c == 18);
            tv[c].exp_shift = '0;
            tv[c].exp_val   = '0;
            for (int i = 0; i < N; i++) begin
                if (c >= 1 + 4*i && c <= 4 + 4*i) begin
                    tv[c].exp_val[i*DW +: DW] = 16'(i + 1);
                end
                if (c == 1 + 4*i) begin
                    tv[c].exp_shift[i] = 1'b1;
                end
            end
        end

        nRST = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        chk("rst.in_ready", 64'(in_ready), 64'd1);
        chk("rst.mac_shift", 64'(mac_shift), 64'd0);
        chk("rst.mac_in_value", mac_in_value, 64'd0);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        chk("rst.mac_count", 64'(mac_count), 64'd0);
        #2 nRST = 1'b1;
        tick();

        for (int c = 0; c < 20; c++) begin
            drive(tv[c].vld, tv[c].data, tv[c].last, tv[c].stall);
            @(negedge clk);
            chk($sformatf("single.c%0d.in_ready", c), 64'(in_ready), 64'(tv[c].exp_rdy));
            chk($sformatf("single.c%0d.mac_shift", c), 64'(mac_shift), 64'(tv[c].exp_shift));
            chk($sformatf("single.c%0d.mac_count", c), 64'(mac_count), 64'(tv[c].exp_cnt));
            chk($sformatf("single.c%0d.busy", c), 64'(busy), 64'(tv[c].exp_busy));
            chk($sformatf("single.c%0d.done", c), 64'(done), 64'(tv[c].exp_done));
            chk($sformatf("single.c%0d.mac_in_value", c), mac_in_value, tv[c].exp_val);
            tick();
        end

        // Back-to-back A, B, C(last): ready only at boundaries, row 2 sees A,B,C
        ndone = 0;
        for (int c = 0; c < 29; c++) begin
            d = (c < 4) ? va : ((c < 8) ? vb : vc);
            drive(c <= 8, d, c == 8, 1'b0);
            @(negedge clk);
            chk($sformatf("b2b.c%0d.in_ready", c), 64'(in_ready),
                64'((c == 0) || (c == 4) || (c == 8) || (c >= 25)));
            chk($sformatf("b2b.c%0d.shift2", c), 64'(mac_shift[2]),
                64'((c == 9) || (c == 13) || (c == 17)));
            if (c == 9 || c == 13 || c == 17) begin
                lane = (c == 9) ? 16'hA2 : ((c == 13) ? 16'hB2 : 16'hC2);
                chk($sformatf("b2b.c%0d.lane2", c), 64'(mac_in_value[2*DW +: DW]), 64'(lane));
            end
            chk($sformatf("b2b.c%0d.done", c), 64'(done), 64'(c == 26));
            if (done === 1'b1) ndone++;
            tick();
        end
        chk("b2b.done_count", 64'(ndone), 64'd1);

        // Gap: no vector at the c=4 boundary leaves a bubble in every row's skewed slot
        for (int c = 0; c < 29; c++) begin
            drive((c == 0) || (c == 8), (c == 0) ? va : vb, c == 8, 1'b0);
            @(negedge clk);
            es = '0;
            for (int i = 0; i < N; i++) begin
                es[i] = (c == 1 + 4*i) || (c == 9 + 4*i);
            end
            chk($sformatf("gap.c%0d.mac_shift", c), 64'(mac_shift), 64'(es));
            chk($sformatf("gap.c%0d.done", c), 64'(done), 64'(c == 26));
            tick();
        end

        // Stall in IDLE with a valid vector: nothing accepted
        drive(1'b1, vc, 1'b1, 1'b1);
        @(negedge clk);
        chk("idle_stall.in_ready", 64'(in_ready), 64'd0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        chk("idle_stall.busy", 64'(busy), 64'd0);
        chk("idle_stall.mac_shift", 64'(mac_shift), 64'd0);
        tick();

        // Three-cycle stall mid-beat (c=6..8) pushes everything after it back by 3
        for (int c = 0; c < 24; c++) begin
            drive(c == 0, (c == 0) ? v1 : vc, c == 0, (c >= 6) && (c <= 8));
            @(negedge clk);
            e = (c <= 6) ? c : ((c <= 9) ? 6 : c - 3);
            chk($sformatf("stall.c%0d.busy", c), 64'(busy), 64'((c >= 1) && (c <= 19)));
            chk($sformatf("stall.c%0d.mac_count", c), 64'(mac_count),
                ((c >= 1) && (c <= 19)) ? 64'((e - 1) % 4) : 64'd0);
            chk($sformatf("stall.c%0d.in_ready", c), 64'(in_ready),
                64'(!((c >= 1) && (c <= 19)) && !((c >= 6) && (c <= 8))));
            es = {c == 16, c == 12, c == 5, c == 1};
            chk($sformatf("stall.c%0d.mac_shift", c), 64'(mac_shift), 64'(es));
            if (c >= 6 && c <= 8) begin
                chk($sformatf("stall.c%0d.lane1", c), 64'(mac_in_value[DW +: DW]), 64'd2);
            end
            chk($sformatf("stall.c%0d.done", c), 64'(done), 64'(c == 21));
            tick();
        end

        // Reset during DRAIN: asynchronous clear, no done, immediate restart
        for (int c = 0; c < 7; c++) begin
            drive(c == 0, v1, c == 0, 1'b0);
            @(negedge clk);
            if (c < 6) tick();
        end
        chk("arst.pre_busy", 64'(busy), 64'd1);
        #2 nRST = 1'b0;
        #1;
        chk("arst.in_ready", 64'(in_ready), 64'd1);
        chk("arst.mac_shift", 64'(mac_shift), 64'd0);
        chk("arst.mac_in_value", mac_in_value, 64'd0);
        chk("arst.busy", 64'(busy), 64'd0);
        chk("arst.mac_count", 64'(mac_count), 64'd0);
        #1 nRST = 1'b1;
        tick();
        for (int k = 0; k < 22; k++) begin
            drive(k == 0, vr, k == 0, 1'b0);
            @(negedge clk);
            if (k == 0) chk("arst.restart_ready", 64'(in_ready), 64'd1);
            if (k == 1) begin
                chk("arst.restart_busy", 64'(busy), 64'd1);
                chk("arst.restart_shift", 64'(mac_shift), 64'd1);
                chk("arst.restart_lane0", 64'(mac_in_value[0 +: DW]), 64'd5);
            end
            chk($sformatf("arst.k%0d.done", k), 64'(done), 64'(k == 18));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
